// File: rtl/ssm_pkg.sv
// ssm_pkg: shared state encoding and access-field constants for the stream sample memory
package ssm_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, DONE_ST} ssm_state_t;
  localparam logic MODE_RANDOM = 1'b0;
  localparam logic MODE_STREAM = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ = 1'b1;
endpackage

// File: rtl/ssm_addr_ptr.sv
// ssm_addr_ptr: loadable, enabled modulo-2**ADDR_W address counter with terminal-count flag
module ssm_addr_ptr #(
  parameter int ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              en,
  output logic [ADDR_W-1:0] ptr,
  output logic              tc
);
  always_ff @(posedge CLK)
    if (!RST) ptr <= '0;
    else if (load) ptr <= load_val;
    else if (en) ptr <= ptr + ADDR_W'(1);
  assign tc = &ptr;
endmodule

// File: rtl/stream_sample_mem.sv
// stream_sample_mem: single-port sample memory with random access and an auto-incrementing stream pointer
module stream_sample_mem
  import ssm_pkg::*;
#(
  parameter int DATA_W = 15,
  parameter int ADDR_W = 6,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CS,
  input  logic              RW,
  input  logic              MODE,
  input  logic              START,
  input  logic [ADDR_W-1:0] ADD,
  input  logic [DATA_W-1:0] DATAIN,
  output logic [DATA_W-1:0] DATAOUT,
  output logic              DOUT_VALID,
  output logic [ADDR_W-1:0] PTR,
  output logic              WRAP_PULSE,
  output logic              DONE
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  ssm_state_t state, state_n;
  logic load, en, acc, tc, wrap, done_n;
  logic [ADDR_W-1:0] addr, load_val;
  ssm_addr_ptr #(.ADDR_W(ADDR_W)) u_ptr (
    .CLK(CLK),
    .RST(RST),
    .load(load),
    .load_val(load_val),
    .en(en),
    .ptr(PTR),
    .tc(tc)
  );
  // START takes priority over the current stream state; a stream access at the top either wraps or ends
  always_comb begin
    state_n = state;
    load = 1'b0;
    en = 1'b0;
    acc = 1'b0;
    wrap = 1'b0;
    done_n = DONE;
    addr = ADD;
    load_val = ADD;
    if (MODE == MODE_RANDOM) acc = CS;
    else if (MODE == MODE_STREAM && START) begin
      state_n = STREAM;
      load = 1'b1;
      done_n = 1'b0;
      acc = CS;
      load_val = CS ? ADD + ADDR_W'(1) : ADD;
      wrap = CS && tc_of(ADD);
    end else if (state == STREAM) begin
      addr = PTR;
      acc = CS;
      en = CS && (WRAP_EN || !tc);
      wrap = CS && tc && WRAP_EN;
      done_n = (CS && tc && !WRAP_EN) ? 1'b1 : DONE;
      state_n = (CS && tc && !WRAP_EN) ? DONE_ST : STREAM;
    end
  end
  function automatic logic tc_of(input logic [ADDR_W-1:0] a);
    return &a;
  endfunction
  always_ff @(posedge CLK)
    if (!RST) begin
      state <= IDLE;
      DATAOUT <= '0;
      DOUT_VALID <= 1'b0;
      WRAP_PULSE <= 1'b0;
      DONE <= 1'b0;
    end else begin
      state <= state_n;
      DONE <= done_n;
      WRAP_PULSE <= wrap;
      DOUT_VALID <= acc && RW == RW_READ;
      if (acc && RW == RW_READ) DATAOUT <= mem[addr];
    end
  always_ff @(posedge CLK)
    if (RST && acc && RW == RW_WRITE) mem[addr] <= DATAIN;
endmodule

// File: tb/tb_stream_sample_mem.sv
// tb_stream_sample_mem: scoreboard/table bench over a ring, a one-shot and a narrow instance
module tb_stream_sample_mem;
  logic clk = 1'b0;
  logic rst_n, cs, rw, mode, start;
  logic [5:0] add;
  logic [14:0] din;
  int sel;
  logic [14:0] dout_w, dout_o;
  logic [7:0] dout_s;
  logic [5:0] ptr_w, ptr_o;
  logic [2:0] ptr_s;
  logic vld_w, vld_o, vld_s, wp_w, wp_o, wp_s, done_w, done_o, done_s;
  int mem_w[64], mem_o[64], mem_s[8];
  int exp_q[$];
  int last_dout;
  int tests = 0, fails = 0;
  typedef struct {
    bit cs, rw, mode, start;
    int add, din;
    bit rd;
    int data, ptr;
    bit wp;
  } vec_t;
  vec_t tbl[9];
  always #5 clk = ~clk;
  stream_sample_mem u_wrap (
    .CLK(clk), .RST(rst_n), .CS(cs && sel == 0), .RW(rw), .MODE(mode), .START(start && sel == 0),
    .ADD(add), .DATAIN(din), .DATAOUT(dout_w), .DOUT_VALID(vld_w), .PTR(ptr_w),
    .WRAP_PULSE(wp_w), .DONE(done_w)
  );
  stream_sample_mem #(.WRAP_EN(1'b0)) u_oneshot (
    .CLK(clk), .RST(rst_n), .CS(cs && sel == 1), .RW(rw), .MODE(mode), .START(start && sel == 1),
    .ADD(add), .DATAIN(din), .DATAOUT(dout_o), .DOUT_VALID(vld_o), .PTR(ptr_o),
    .WRAP_PULSE(wp_o), .DONE(done_o)
  );
  stream_sample_mem #(.DATA_W(8), .ADDR_W(3)) u_small (
    .CLK(clk), .RST(rst_n), .CS(cs && sel == 2), .RW(rw), .MODE(mode), .START(start && sel == 2),
    .ADD(add[2:0]), .DATAIN(din[7:0]), .DATAOUT(dout_s), .DOUT_VALID(vld_s), .PTR(ptr_s),
    .WRAP_PULSE(wp_s), .DONE(done_s)
  );
  function automatic int cur_dout();
    return sel == 0 ? int'(dout_w) : sel == 1 ? int'(dout_o) : int'(dout_s);
  endfunction
  function automatic int cur_vld();
    return sel == 0 ? int'(vld_w) : sel == 1 ? int'(vld_o) : int'(vld_s);
  endfunction
  function automatic int cur_ptr();
    return sel == 0 ? int'(ptr_w) : sel == 1 ? int'(ptr_o) : int'(ptr_s);
  endfunction
  function automatic int cur_wp();
    return sel == 0 ? int'(wp_w) : sel == 1 ? int'(wp_o) : int'(wp_s);
  endfunction
  function automatic int cur_done();
    return sel == 0 ? int'(done_w) : sel == 1 ? int'(done_o) : int'(done_s);
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s (dut %0d, t=%0t): got %0d expected %0d", name, sel, $time, act, exp);
    end
  endtask
  // Applies one cycle of stimulus; a read pushes its expected word, which is popped once the DUT answers
  task automatic drive(input bit c, input bit r, input bit m, input bit st, input int a, input int d,
                       input bit rd, input int xd);
    int x;
    cs = c;
    rw = r;
    mode = m;
    start = st;
    add = 6'(a);
    din = 15'(d);
    if (rd) exp_q.push_back(xd);
    @(posedge clk);
    #1;
    chk("dout_valid", cur_vld(), int'(rd));
    if (rd) begin
      x = exp_q.pop_front();
      chk("dout", cur_dout(), x);
      last_dout = x;
    end
  endtask
  task automatic rd_rand(input int a, input int x);
    drive(1, 1, 0, 0, a, 0, 1, x);
  endtask
  initial begin
    rst_n = 1'b0;
    cs = 1'b0;
    rw = 1'b0;
    mode = 1'b0;
    start = 1'b0;
    add = '0;
    din = '0;
    sel = 0;
    last_dout = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      chk("rst_dout", cur_dout(), 0);
      chk("rst_valid", cur_vld(), 0);
      chk("rst_ptr", cur_ptr(), 0);
      chk("rst_wrap", cur_wp(), 0);
      chk("rst_done", cur_done(), 0);
    end
    rst_n = 1'b1;
    sel = 0;
    for (int a = 0; a < 64; a++) begin
      drive(1, 0, 0, 0, a, a + 100, 0, 0);
      mem_w[a] = a + 100;
    end
    for (int a = 0; a < 64; a++) rd_rand(a, mem_w[a]);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    chk("t1_hold", cur_dout(), last_dout);
    chk("t1_ptr", cur_ptr(), 0);
    drive(0, 0, 1, 1, 60, 0, 0, 0);
    chk("t2_start_ptr", cur_ptr(), 60);
    for (int i = 1; i <= 6; i++) begin
      drive(1, 0, 1, 0, 0, i, 0, 0);
      mem_w[(59 + i) % 64] = i;
      chk("t2_ptr", cur_ptr(), (60 + i) % 64);
      chk("t2_wrap", cur_wp(), int'(i == 4));
    end
    for (int k = 60; k < 67; k++) rd_rand(k % 64, mem_w[k % 64]);
    tbl[0] = '{1, 1, 1, 1, 10, 0, 1, mem_w[10], 11, 0};
    tbl[1] = '{0, 1, 1, 0, 0, 0, 0, 0, 11, 0};
    tbl[2] = '{0, 1, 0, 0, 0, 0, 0, 0, 11, 0};
    tbl[3] = '{1, 1, 1, 0, 0, 0, 1, mem_w[11], 12, 0};
    tbl[4] = '{1, 1, 0, 0, 60, 0, 1, mem_w[60], 12, 0};
    tbl[5] = '{1, 0, 1, 0, 0, 7777, 0, 0, 13, 0};
    tbl[6] = '{0, 0, 1, 1, 63, 0, 0, 0, 63, 0};
    tbl[7] = '{1, 1, 1, 0, 0, 0, 1, mem_w[63], 0, 1};
    tbl[8] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].cs, tbl[i].rw, tbl[i].mode, tbl[i].start, tbl[i].add, tbl[i].din, tbl[i].rd, tbl[i].data);
      chk("t4_ptr", cur_ptr(), tbl[i].ptr);
      chk("t4_wrap", cur_wp(), int'(tbl[i].wp));
      if (!tbl[i].rd) chk("t4_hold", cur_dout(), last_dout);
    end
    mem_w[12] = 7777;
    rd_rand(12, mem_w[12]);
    sel = 1;
    drive(1, 0, 0, 0, 0, 55, 0, 0);
    mem_o[0] = 55;
    drive(0, 0, 1, 1, 62, 0, 0, 0);
    chk("t3_start_ptr", cur_ptr(), 62);
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 1, 0, 0, 300 + i, 0, 0);
      chk("t3_ptr", cur_ptr(), 63);
      chk("t3_done", cur_done(), int'(i >= 2));
      chk("t3_wrap", cur_wp(), 0);
    end
    mem_o[62] = 301;
    mem_o[63] = 302;
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    chk("t3_blocked_ptr", cur_ptr(), 63);
    rd_rand(62, mem_o[62]);
    rd_rand(63, mem_o[63]);
    rd_rand(0, mem_o[0]);
    drive(0, 0, 1, 1, 5, 0, 0, 0);
    chk("t3_restart_done", cur_done(), 0);
    chk("t3_restart_ptr", cur_ptr(), 5);
    sel = 0;
    drive(0, 0, 1, 1, 15, 0, 0, 0);
    for (int p = 15; p < 20; p++) begin
      drive(1, 0, 1, 0, 0, 200 + p, 0, 0);
      mem_w[p] = 200 + p;
    end
    chk("t5_ptr", cur_ptr(), 20);
    rd_rand(15, mem_w[15]);
    rst_n = 1'b0;
    drive(1, 0, 1, 0, 0, 999, 0, 0);
    rst_n = 1'b1;
    chk("t5_ptr_rst", cur_ptr(), 0);
    chk("t5_done_rst", cur_done(), 0);
    chk("t5_dout_rst", cur_dout(), 0);
    chk("t5_wrap_rst", cur_wp(), 0);
    rd_rand(19, mem_w[19]);
    rd_rand(20, mem_w[20]);
    sel = 2;
    drive(0, 0, 1, 1, 0, 0, 0, 0);
    chk("t6_start_ptr", cur_ptr(), 0);
    for (int i = 1; i <= 10; i++) begin
      drive(1, 0, 1, 0, 0, i, 0, 0);
      mem_s[(i - 1) % 8] = i;
      chk("t6_ptr", cur_ptr(), i % 8);
      chk("t6_wrap", cur_wp(), int'(i == 8));
    end
    for (int k = 0; k < 8; k++) rd_rand(k, mem_s[k]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
